// File: rtl/gesummv_pipe.sv
// -----------------------------------------------------------------------------
// gesummv_pipe
//
// Streaming N x N signed integer GESUMMV kernel:
//   tmp = A*x
//   y   = alpha*(A*x) + beta*(B*x)
// One matrix column (j) is issued per cycle to external single-port memories
// with one cycle of read latency. Each row takes N+4 cycles:
//   ISSUE (N) -> DRAIN (2) -> SCALE (1) -> WRITE (1).
//
// Optional feature macro: GESUMMV_PIPE_SAT_EN
//   defined   : every product reduction and every addition saturates to the
//               signed DATA_W range.
//   undefined : two's-complement wrap (low DATA_W bits).
//   Latency is identical in both builds.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tstart                   start pulse, sampled only while idle
//   alpha, beta              signed scalars, latched on the accepted tstart
//   a_addr/a_rd_en/a_rd_data A matrix read port, addr = {i,j}
//   b_addr/b_rd_en/b_rd_data B matrix read port, addr = {i,j}
//   x_addr/x_rd_en/x_rd_data x vector read port, addr = j
//   tmp_addr/_wr_en/_wr_data tmp result write port, addr = i
//   y_addr/_wr_en/_wr_data   y result write port, addr = i
//   busy                     high from the cycle after start through final WRITE
//   done                     one-cycle pulse after the final WRITE
// -----------------------------------------------------------------------------
module gesummv_pipe #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tstart,
  input  logic [DATA_W-1:0]    alpha,
  input  logic [DATA_W-1:0]    beta,
  output logic [2*IDX_W-1:0]   a_addr,
  output logic                 a_rd_en,
  input  logic [DATA_W-1:0]    a_rd_data,
  output logic [2*IDX_W-1:0]   b_addr,
  output logic                 b_rd_en,
  input  logic [DATA_W-1:0]    b_rd_data,
  output logic [IDX_W-1:0]     x_addr,
  output logic                 x_rd_en,
  input  logic [DATA_W-1:0]    x_rd_data,
  output logic [IDX_W-1:0]     tmp_addr,
  output logic                 tmp_wr_en,
  output logic [DATA_W-1:0]    tmp_wr_data,
  output logic [IDX_W-1:0]     y_addr,
  output logic                 y_wr_en,
  output logic [DATA_W-1:0]    y_wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

`ifdef GESUMMV_PIPE_SAT_EN
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  // Full-width signed product reduced to DATA_W.
  function automatic logic signed [DATA_W-1:0] mul_red(
    input logic signed [DATA_W-1:0] op_a,
    input logic signed [DATA_W-1:0] op_b
  );
`ifdef GESUMMV_PIPE_SAT_EN
    logic signed [2*DATA_W-1:0] full;
    logic        [DATA_W:0]     hi;
    full = $signed({{DATA_W{op_a[DATA_W-1]}}, op_a}) *
           $signed({{DATA_W{op_b[DATA_W-1]}}, op_b});
    // The product fits when its top DATA_W+1 bits are all sign copies.
    hi = full[2*DATA_W-1:DATA_W-1];
    if ((&hi) || (~|hi)) mul_red = full[DATA_W-1:0];
    else                 mul_red = full[2*DATA_W-1] ? SMIN : SMAX;
`else
    // Low DATA_W bits of a signed product equal the low bits of the full one.
    mul_red = op_a * op_b;
`endif
  endfunction

  // Signed DATA_W addition reduced to DATA_W.
  function automatic logic signed [DATA_W-1:0] add_red(
    input logic signed [DATA_W-1:0] op_a,
    input logic signed [DATA_W-1:0] op_b
  );
`ifdef GESUMMV_PIPE_SAT_EN
    logic [DATA_W:0] s;
    s = {op_a[DATA_W-1], op_a} + {op_b[DATA_W-1], op_b};
    if (s[DATA_W] != s[DATA_W-1]) add_red = s[DATA_W] ? SMIN : SMAX;
    else                          add_red = s[DATA_W-1:0];
`else
    add_red = op_a + op_b;
`endif
  endfunction

  // Control state
  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic              drn_q, drn_d;
  logic              done_q, done_d;
  logic signed [DATA_W-1:0] alpha_q, alpha_d;
  logic signed [DATA_W-1:0] beta_q, beta_d;

  // Pipeline and accumulation state
  logic              vld_p1_q;
  logic              vld_p2_q;
  logic signed [DATA_W-1:0] prod_a_p2_q;
  logic signed [DATA_W-1:0] prod_b_p2_q;
  logic signed [DATA_W-1:0] acc_a_q;
  logic signed [DATA_W-1:0] acc_b_q;
  logic signed [DATA_W-1:0] pa_q;
  logic signed [DATA_W-1:0] pb_q;

  logic issue;
  logic wr;
  logic acc_clr;

  assign issue   = (state_q == S_ISSUE);
  assign wr      = (state_q == S_WRITE);
  assign acc_clr = issue && (j_q == '0);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    drn_d   = drn_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tstart) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          alpha_d = $signed(alpha);
          beta_d  = $signed(beta);
        end
      end
      S_ISSUE: begin
        if (j_q == LAST) begin
          j_d     = '0;
          drn_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles let the last column's product reach the accumulators.
        if (drn_q) begin
          drn_d   = 1'b0;
          state_d = S_SCALE;
        end else begin
          drn_d = 1'b1;
        end
      end
      S_SCALE: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (i_q == LAST) begin
          i_d     = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          i_d     = i_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      drn_q    <= 1'b0;
      done_q   <= 1'b0;
      alpha_q  <= '0;
      beta_q   <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      drn_q    <= drn_d;
      done_q   <= done_d;
      alpha_q  <= alpha_d;
      beta_q   <= beta_d;
      // p0 -> p1: read issued this cycle, data returns next cycle
      vld_p1_q <= issue;
      // p1 -> p2: products registered alongside their valid
      vld_p2_q <= vld_p1_q;
      // p2 -> accumulators
      if (acc_clr) begin
        acc_a_q <= '0;
        acc_b_q <= '0;
      end else if (vld_p2_q) begin
        acc_a_q <= add_red(acc_a_q, prod_a_p2_q);
        acc_b_q <= add_red(acc_b_q, prod_b_p2_q);
      end
      // accumulators -> scaled terms
      if (state_q == S_SCALE) begin
        pa_q <= mul_red(alpha_q, acc_a_q);
        pb_q <= mul_red(beta_q, acc_b_q);
      end
    end
  end

  // p1 -> p2: memory data multiplied only in the slot it belongs to
  always_ff @(posedge clk) begin
    if (vld_p1_q) begin
      prod_a_p2_q <= mul_red($signed(a_rd_data), $signed(x_rd_data));
      prod_b_p2_q <= mul_red($signed(b_rd_data), $signed(x_rd_data));
    end
  end

  assign a_rd_en     = issue;
  assign b_rd_en     = issue;
  assign x_rd_en     = issue;
  assign a_addr      = issue ? {i_q, j_q} : '0;
  assign b_addr      = issue ? {i_q, j_q} : '0;
  assign x_addr      = issue ? j_q : '0;

  assign tmp_wr_en   = wr;
  assign y_wr_en     = wr;
  assign tmp_addr    = wr ? i_q : '0;
  assign y_addr      = wr ? i_q : '0;
  assign tmp_wr_data = wr ? acc_a_q : '0;
  assign y_wr_data   = wr ? add_red(pa_q, pb_q) : '0;

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_gesummv_pipe.sv
// -----------------------------------------------------------------------------
// tb_gesummv_pipe
//
// Three instances of gesummv_pipe share clk/rst/alpha/beta:
//   u4 : N=4, DATA_W=32  (basic, ignored restart, reset mid-row, back-to-back)
//   u8 : N=8, DATA_W=32  (full sweep)
//   uw : N=4, DATA_W=8   (overflow, wrap or saturate per GESUMMV_PIPE_SAT_EN)
// Expected writes are queued per instance when a run is started and popped by
// a monitor whenever the instance writes.
// -----------------------------------------------------------------------------
module tb_gesummv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic signed [31:0] alpha, beta;
  int tests = 0;
  int fails = 0;

  longint A[8][8];
  longint B[8][8];
  longint X[8];

  typedef struct {
    int     cyc;
    int     addr;
    longint tmp;
    longint y;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t qw[$];

  // ---------------- u4 ----------------
  logic        t4;
  logic [3:0]  a4_addr, b4_addr;
  logic [1:0]  x4_addr, tmp4_addr, y4_addr;
  logic        a4_en, b4_en, x4_en, tmp4_en, y4_en, busy4, done4;
  logic [31:0] a4_d, b4_d, x4_d, tmp4_d, y4_d;

  gesummv_pipe #(.N(4), .DATA_W(32)) u4 (
    .clk(clk), .rst(rst), .tstart(t4), .alpha(alpha), .beta(beta),
    .a_addr(a4_addr), .a_rd_en(a4_en), .a_rd_data(a4_d),
    .b_addr(b4_addr), .b_rd_en(b4_en), .b_rd_data(b4_d),
    .x_addr(x4_addr), .x_rd_en(x4_en), .x_rd_data(x4_d),
    .tmp_addr(tmp4_addr), .tmp_wr_en(tmp4_en), .tmp_wr_data(tmp4_d),
    .y_addr(y4_addr), .y_wr_en(y4_en), .y_wr_data(y4_d),
    .busy(busy4), .done(done4)
  );

  always @(posedge clk) begin
    a4_d <= a4_en ? 32'(A[a4_addr[3:2]][a4_addr[1:0]]) : $urandom;
    b4_d <= b4_en ? 32'(B[b4_addr[3:2]][b4_addr[1:0]]) : $urandom;
    x4_d <= x4_en ? 32'(X[x4_addr]) : $urandom;
  end

  // ---------------- u8 ----------------
  logic        t8;
  logic [5:0]  a8_addr, b8_addr;
  logic [2:0]  x8_addr, tmp8_addr, y8_addr;
  logic        a8_en, b8_en, x8_en, tmp8_en, y8_en, busy8, done8;
  logic [31:0] a8_d, b8_d, x8_d, tmp8_d, y8_d;

  gesummv_pipe #(.N(8), .DATA_W(32)) u8 (
    .clk(clk), .rst(rst), .tstart(t8), .alpha(alpha), .beta(beta),
    .a_addr(a8_addr), .a_rd_en(a8_en), .a_rd_data(a8_d),
    .b_addr(b8_addr), .b_rd_en(b8_en), .b_rd_data(b8_d),
    .x_addr(x8_addr), .x_rd_en(x8_en), .x_rd_data(x8_d),
    .tmp_addr(tmp8_addr), .tmp_wr_en(tmp8_en), .tmp_wr_data(tmp8_d),
    .y_addr(y8_addr), .y_wr_en(y8_en), .y_wr_data(y8_d),
    .busy(busy8), .done(done8)
  );

  always @(posedge clk) begin
    a8_d <= a8_en ? 32'(A[a8_addr[5:3]][a8_addr[2:0]]) : $urandom;
    b8_d <= b8_en ? 32'(B[b8_addr[5:3]][b8_addr[2:0]]) : $urandom;
    x8_d <= x8_en ? 32'(X[x8_addr]) : $urandom;
  end

  // ---------------- uw ----------------
  logic        tw;
  logic [3:0]  aw_addr, bw_addr;
  logic [1:0]  xw_addr, tmpw_addr, yw_addr;
  logic        aw_en, bw_en, xw_en, tmpw_en, yw_en, busyw, donew;
  logic [7:0]  aw_d, bw_d, xw_d, tmpw_d, yw_d;

  gesummv_pipe #(.N(4), .DATA_W(8)) uw (
    .clk(clk), .rst(rst), .tstart(tw), .alpha(alpha[7:0]), .beta(beta[7:0]),
    .a_addr(aw_addr), .a_rd_en(aw_en), .a_rd_data(aw_d),
    .b_addr(bw_addr), .b_rd_en(bw_en), .b_rd_data(bw_d),
    .x_addr(xw_addr), .x_rd_en(xw_en), .x_rd_data(xw_d),
    .tmp_addr(tmpw_addr), .tmp_wr_en(tmpw_en), .tmp_wr_data(tmpw_d),
    .y_addr(yw_addr), .y_wr_en(yw_en), .y_wr_data(yw_d),
    .busy(busyw), .done(donew)
  );

  always @(posedge clk) begin
    aw_d <= aw_en ? 8'(A[aw_addr[3:2]][aw_addr[1:0]]) : 8'($urandom);
    bw_d <= bw_en ? 8'(B[bw_addr[3:2]][bw_addr[1:0]]) : 8'($urandom);
    xw_d <= xw_en ? 8'(X[xw_addr]) : 8'($urandom);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reduce an exact integer to a w-bit signed result.
  function automatic longint red(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
`ifdef GESUMMV_PIPE_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    begin
      longint t;
      t = v & ((longint'(1) <<< w) - 1);
      if (t > hi) t = t - (longint'(1) <<< w);
      return t;
    end
`endif
  endfunction

  task automatic push_rows(input int id, input int n, input int w, input int c0,
                           input longint al, input longint be, input int rows);
    for (int r = 0; r < rows; r++) begin
      longint sa, sb, pa, pb;
      exp_t e;
      sa = 0;
      sb = 0;
      for (int j = 0; j < n; j++) begin
        sa = red(sa + red(A[r][j] * X[j], w), w);
        sb = red(sb + red(B[r][j] * X[j], w), w);
      end
      pa = red(al * sa, w);
      pb = red(be * sb, w);
      e.cyc  = c0 + (r + 1) * (n + 4);
      e.addr = r;
      e.tmp  = sa;
      e.y    = red(pa + pb, w);
      case (id)
        0:       q4.push_back(e);
        1:       q8.push_back(e);
        default: qw.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int id, input logic ten, input logic yen,
                     input int taddr, input int yaddr,
                     input longint tdat, input longint ydat);
    exp_t e;
    int n;
    if (!ten && !yen) return;
    n = (id == 0) ? q4.size() : (id == 1) ? q8.size() : qw.size();
    if (n == 0) begin
      chk($sformatf("unexpected_write_dut%0d", id), longint'({ten, yen}), 0);
      return;
    end
    case (id)
      0:       e = q4.pop_front();
      1:       e = q8.pop_front();
      default: e = qw.pop_front();
    endcase
    chk($sformatf("wr_cycle_dut%0d_row%0d", id, e.addr), cyc, e.cyc);
    chk($sformatf("tmp_en_dut%0d", id), ten, 1);
    chk($sformatf("y_en_dut%0d", id), yen, 1);
    chk($sformatf("tmp_addr_dut%0d", id), taddr, e.addr);
    chk($sformatf("y_addr_dut%0d", id), yaddr, e.addr);
    chk($sformatf("tmp_data_dut%0d_row%0d", id, e.addr), tdat, e.tmp);
    chk($sformatf("y_data_dut%0d_row%0d", id, e.addr), ydat, e.y);
  endtask

  always @(negedge clk) mon(0, tmp4_en, y4_en, int'(tmp4_addr), int'(y4_addr),
                            longint'($signed(tmp4_d)), longint'($signed(y4_d)));
  always @(negedge clk) mon(1, tmp8_en, y8_en, int'(tmp8_addr), int'(y8_addr),
                            longint'($signed(tmp8_d)), longint'($signed(y8_d)));
  always @(negedge clk) mon(2, tmpw_en, yw_en, int'(tmpw_addr), int'(yw_addr),
                            longint'($signed(tmpw_d)), longint'($signed(yw_d)));

  // Start u4, optionally pulse tstart again (with alpha_p) at p1/p2 and rst at rs.
  task automatic run4(input int p1, input int p2, input int rs, input int len,
                      input logic signed [31:0] alpha_p,
                      output int bn, output int dn, output int da);
    int c0, rel, zbad;
    logic nz;
    bn = 0; dn = 0; da = -1; zbad = 0;
    c0 = cyc;
    t4 = 1'b1;
    @(posedge clk); #1;
    rel = cyc - c0;
    while (rel <= len) begin
      t4  = (rel == p1) || (rel == p2);
      if (t4) alpha = alpha_p;
      rst = (rel == rs);
      @(negedge clk);
      if (busy4) bn++;
      if (done4) begin dn++; da = rel; end
      if (rel == 1) begin
        chk("issue0_a_en", a4_en, 1);
        chk("issue0_b_en", b4_en, 1);
        chk("issue0_x_en", x4_en, 1);
        chk("issue0_a_addr", a4_addr, 0);
      end
      if (rel == 2) begin
        chk("issue1_a_addr", a4_addr, 1);
        chk("issue1_b_addr", b4_addr, 1);
        chk("issue1_x_addr", x4_addr, 1);
      end
      if (rel == 5) begin
        chk("drain_a_en", a4_en, 0);
        chk("drain_a_addr", a4_addr, 0);
      end
      nz = ({busy4, done4, a4_en, b4_en, x4_en, tmp4_en, y4_en, a4_addr, b4_addr,
             x4_addr, tmp4_addr, y4_addr, tmp4_d, y4_d} != '0);
      if (rs >= 0 && rel == rs + 1) chk("rst_outs_zero", nz, 0);
      if (rs >= 0 && rel > rs && nz) zbad++;
      @(posedge clk); #1;
      rel = cyc - c0;
    end
    t4  = 1'b0;
    rst = 1'b0;
    if (rs >= 0) chk("rst_outs_stay_zero", zbad, 0);
  endtask

  task automatic wait_run(input int id, input int len,
                          output int bn, output int dn, output int da);
    int c0, rel;
    bn = 0; dn = 0; da = -1;
    c0 = cyc;
    if (id == 1) t8 = 1'b1;
    else         tw = 1'b1;
    @(posedge clk); #1;
    t8 = 1'b0;
    tw = 1'b0;
    rel = cyc - c0;
    while (rel <= len) begin
      @(negedge clk);
      if ((id == 1) ? busy8 : busyw) bn++;
      if ((id == 1) ? done8 : donew) begin dn++; da = rel; end
      @(posedge clk); #1;
      rel = cyc - c0;
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) begin
      X[i] = 0;
      for (int j = 0; j < 8; j++) begin
        A[i][j] = (i == j && i < 4) ? 1 : 0;
        B[i][j] = (i == j && i < 4) ? 2 : 0;
      end
    end
    for (int j = 0; j < 4; j++) X[j] = j + 1;
    alpha = 3;
    beta  = 5;
  endtask

  initial begin
    int bn, dn, da;
    rst   = 1'b1;
    t4    = 1'b0;
    t8    = 1'b0;
    tw    = 1'b0;
    alpha = '0;
    beta  = '0;
    load_basic();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_a_en", a4_en, 0);
    chk("rst_tmp_en", tmp4_en, 0);
    chk("rst_y_data", y4_d, 0);
    chk("rst_busy8", busy8, 0);
    @(posedge clk); #1;

    // Basic: expected tmp=[1,2,3,4], y=[13,26,39,52]
    load_basic();
    push_rows(0, 4, 32, cyc, 3, 5, 4);
    chk("basic_model_y0", q4[0].y, 13);
    chk("basic_model_y3", q4[3].y, 52);
    run4(-1, -1, -1, 40, 3, bn, dn, da);
    chk("basic_busy_cycles", bn, 32);
    chk("basic_done_count", dn, 1);
    chk("basic_done_cycle", da, 33);
    chk("basic_queue_empty", q4.size(), 0);

    // Ignored restart with a different alpha at cycles 10 and 20
    load_basic();
    push_rows(0, 4, 32, cyc, 3, 5, 4);
    run4(10, 20, -1, 40, 9, bn, dn, da);
    chk("restart_done_count", dn, 1);
    chk("restart_done_cycle", da, 33);
    chk("restart_queue_empty", q4.size(), 0);

    // Reset mid-row: only row 0 written
    load_basic();
    push_rows(0, 4, 32, cyc, 3, 5, 1);
    run4(-1, -1, 14, 30, 3, bn, dn, da);
    chk("rstmid_done_count", dn, 0);
    chk("rstmid_queue_empty", q4.size(), 0);

    // Full run after reset
    load_basic();
    push_rows(0, 4, 32, cyc, 3, 5, 4);
    run4(-1, -1, -1, 40, 3, bn, dn, da);
    chk("postrst_done_cycle", da, 33);
    chk("postrst_queue_empty", q4.size(), 0);

    // Back-to-back: second start on the done cycle with alpha=6
    load_basic();
    push_rows(0, 4, 32, cyc, 3, 5, 4);
    push_rows(0, 4, 32, cyc + 33, 6, 5, 4);
    run4(33, -1, -1, 70, 6, bn, dn, da);
    chk("b2b_done_count", dn, 2);
    chk("b2b_busy_cycles", bn, 64);
    chk("b2b_last_done", da, 66);
    chk("b2b_queue_empty", q4.size(), 0);

    // Full N=8 sweep
    for (int i = 0; i < 8; i++) begin
      X[i] = i + 1;
      for (int j = 0; j < 8; j++) begin
        A[i][j] = i + j;
        B[i][j] = i - j;
      end
    end
    alpha = 2;
    beta  = -1;
    push_rows(1, 8, 32, cyc, 2, -1, 8);
    wait_run(1, 110, bn, dn, da);
    chk("n8_busy_cycles", bn, 96);
    chk("n8_done_cycle", da, 97);
    chk("n8_done_count", dn, 1);
    chk("n8_queue_empty", q8.size(), 0);

    // Overflow with DATA_W=8
    for (int i = 0; i < 8; i++) begin
      X[i] = 2;
      for (int j = 0; j < 8; j++) begin
        A[i][j] = 100;
        B[i][j] = 0;
      end
    end
    alpha = 1;
    beta  = 0;
    push_rows(2, 4, 8, cyc, 1, 0, 4);
`ifdef GESUMMV_PIPE_SAT_EN
    chk("ovf_model_tmp", qw[0].tmp, 127);
    chk("ovf_model_y", qw[0].y, 127);
`else
    chk("ovf_model_tmp", qw[0].tmp, 32);
    chk("ovf_model_y", qw[0].y, 32);
`endif
    wait_run(2, 40, bn, dn, da);
    chk("ovf_done_cycle", da, 33);
    chk("ovf_queue_empty", qw.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
